// File: rtl/bt656_pkg.sv
// Shared BT.656 geometry, sync-word constants and the XYZ protection-bit helper.
package bt656_pkg;

  localparam logic [1:0] MODE_NTSC = 2'd0;
  localparam logic [1:0] MODE_PAL  = 2'd1;

  localparam logic [7:0] BLANK_C8  = 8'h80;
  localparam logic [7:0] BLANK_Y8  = 8'h10;
  localparam logic [7:0] PRE_ONES8 = 8'hFF;
  localparam logic [7:0] PRE_ZERO8 = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Active windows are inclusive line ranges; F=1 below f_top_end or from f_bot_start on.
  typedef struct packed {
    logic [10:0] hsize;
    logic [9:0]  vsize;
    logic [10:0] sav_start;
    logic [10:0] act_start;
    logic [9:0]  f_top_end;
    logic [9:0]  f_bot_start;
    logic [9:0]  act0_first;
    logic [9:0]  act0_last;
    logic [9:0]  act1_first;
    logic [9:0]  act1_last;
  } geom_t;

  localparam geom_t GEOM_NTSC = '{
    hsize: 11'd1716, vsize: 10'd525, sav_start: 11'd272, act_start: 11'd276,
    f_top_end: 10'd3, f_bot_start: 10'd265,
    act0_first: 10'd20, act0_last: 10'd262, act1_first: 10'd282, act1_last: 10'd524
  };

  localparam geom_t GEOM_PAL = '{
    hsize: 11'd1728, vsize: 10'd625, sav_start: 11'd284, act_start: 11'd288,
    f_top_end: 10'd0, f_bot_start: 10'd312,
    act0_first: 10'd22, act0_last: 10'd309, act1_first: 10'd335, act1_last: 10'd622
  };

  function automatic geom_t geom(input logic pal);
    return pal ? GEOM_PAL : GEOM_NTSC;
  endfunction

  function automatic logic [7:0] xyz(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_raster_cnt.sv
// Horizontal/vertical sample position counters with an end-of-frame strobe.
module bt656_raster_cnt
  import bt656_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        run_i,
  input  logic [10:0] hsize_i,
  input  logic [9:0]  vsize_i,
  output logic [10:0] hpos_o,
  output logic [9:0]  vpos_o,
  output logic        eof_o
);

  logic [10:0] hpos_q;
  logic [9:0]  vpos_q;

  wire h_last = (hpos_q == hsize_i - 11'd1);
  wire v_last = (vpos_q == vsize_i - 10'd1);

  // Counters rest at 0 outside RUN so a new run always starts at line 0, sample 0.
  wire [10:0] hpos_d = (!run_i || h_last) ? 11'd0 : hpos_q + 11'd1;
  wire [9:0]  vpos_d = !run_i ? 10'd0 :
                       (h_last ? (v_last ? 10'd0 : vpos_q + 10'd1) : vpos_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hpos_q <= 11'd0;
      vpos_q <= 10'd0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  assign hpos_o = hpos_q;
  assign vpos_o = vpos_q;
  assign eof_o  = run_i & h_last & v_last;

endmodule

// File: rtl/bt656_timing_gen.sv
// BT.656 timing generator: run/idle FSM, line decode, sync/blank/pixel output mux,
// upstream handshake and saturating underflow counter.
module bt656_timing_gen
  import bt656_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int UFLOW_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  din,
  input  logic               din_valid,
  output logic               din_rdy,
  output logic [10:0]        hcnt,
  output logic [10:0]        vcnt,
  output logic [DATA_W-1:0]  dout,
  output logic               frame_start,
  output logic               running,
  output logic               cfg_err,
  output logic [UFLOW_W-1:0] uflow_cnt
);

  // Preamble ones stay all-ones at 10 bits; every other 8-bit code is shifted up.
  function automatic logic [DATA_W-1:0] widen(input logic [7:0] v8);
    logic [DATA_W-1:0] w;
    w = DATA_W'(v8) << (DATA_W - 8);
    if (v8 == PRE_ONES8) w = '1;
    return w;
  endfunction

  state_e              state_q, state_d;
  logic                pal_q, pal_d;
  logic                cfg_err_q, cfg_err_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                fs_q, fs_d;
  logic [UFLOW_W-1:0]  uflow_cnt_q;

  logic [10:0]         hpos;
  logic [9:0]          vpos;
  logic                eof;
  geom_t               g;

  logic                f_bit, v_bit, is_eav, is_sav, is_act;
  logic [10:0]         h_rel;
  logic [9:0]          v_rel;
  logic [DATA_W-1:0]   sync_word, blank_word;

  wire mode_rsvd = mode[1];

  assign g = geom(pal_q);

  bt656_raster_cnt u_raster (
    .clk     (clk),
    .resetn  (resetn),
    .run_i   (running),
    .hsize_i (g.hsize),
    .vsize_i (g.vsize),
    .hpos_o  (hpos),
    .vpos_o  (vpos),
    .eof_o   (eof)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pal_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pal_q     <= pal_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Mode is only (re)latched when starting from IDLE or on the last sample of a frame.
  always_comb begin
    state_d   = state_q;
    pal_d     = pal_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (mode_rsvd) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            pal_d   = (mode == MODE_PAL);
          end
        end
      end
      ST_RUN: begin
        if (eof) begin
          if (mode_rsvd) cfg_err_d = 1'b1;
          if (!enable || mode_rsvd) state_d = ST_IDLE;
          else                      pal_d   = (mode == MODE_PAL);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running  = (state_q == ST_RUN);
    f_bit    = (vpos < g.f_top_end) || (vpos >= g.f_bot_start);
    v_bit    = !(((vpos >= g.act0_first) && (vpos <= g.act0_last)) ||
                 ((vpos >= g.act1_first) && (vpos <= g.act1_last)));
    is_eav   = (hpos < 11'd4);
    is_sav   = (hpos >= g.sav_start) && (hpos < g.act_start);
    is_act   = (hpos >= g.act_start);
    din_rdy  = running & is_act & ~v_bit;
    h_rel    = hpos - g.act_start;
    v_rel    = vpos - (f_bit ? g.act1_first : g.act0_first);
    hcnt     = din_rdy ? (h_rel >> 1) : 11'd0;
    vcnt     = din_rdy ? {v_rel, f_bit} : 11'd0;

    // EAV at 0 and SAV at a multiple of 4, so hpos[1:0] indexes the word in both.
    case (hpos[1:0])
      2'd0:    sync_word = widen(PRE_ONES8);
      2'd3:    sync_word = widen(xyz(f_bit, v_bit, is_eav));
      default: sync_word = widen(PRE_ZERO8);
    endcase
    // Blanking and the active window both begin on an even hpos, so C lands on even hpos.
    blank_word = hpos[0] ? widen(BLANK_Y8) : widen(BLANK_C8);

    if (!running)                dout_d = '0;
    else if (is_eav || is_sav)   dout_d = sync_word;
    else if (din_rdy && din_valid) dout_d = din;
    else                         dout_d = blank_word;

    fs_d = running && (hpos == 11'd0) && (vpos == 10'd0);
  end

  wire [UFLOW_W-1:0] uflow_cnt_d = (din_rdy && !din_valid && !(&uflow_cnt_q)) ?
                                   uflow_cnt_q + UFLOW_W'(1) : uflow_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_q      <= '0;
      fs_q        <= 1'b0;
      uflow_cnt_q <= '0;
    end else begin
      dout_q      <= dout_d;
      fs_q        <= fs_d;
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign dout        = dout_q;
  assign frame_start = fs_q;
  assign cfg_err     = cfg_err_q;
  assign uflow_cnt   = uflow_cnt_q;

endmodule
